// File: rtl/wb_uart_tracer.sv
// Register write-back tracer: buffers {rd, data} events in a small FIFO and
// streams each one as a 6-byte 8N1 UART frame (A5, rd, data MSB..LSB) on usb_tx.
module wb_uart_tracer #(
    parameter int CLKS_PER_BIT = 868,
    parameter int FIFO_DEPTH   = 8
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        wb_valid,
    input  logic [4:0]  wb_rd,
    input  logic [31:0] wb_data,
    output logic        usb_tx,
    output logic        busy,
    output logic        fifo_full,
    output logic [7:0]  drop_count
);

    // state | meaning
    // IDLE  | line high, waiting for a queued event
    // START | start bit (0) of the current byte
    // DATA  | eight data bits, LSB first
    // STOP  | stop bit (1); chains into the next byte or returns to IDLE
    typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;

    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int CW = $clog2(CLKS_PER_BIT);
    localparam logic [CW-1:0] BAUD_RELOAD = CW'(CLKS_PER_BIT - 1);

    state_t          state, state_next;
    logic [36:0]     mem [FIFO_DEPTH];
    logic [AW:0]     wr_ptr, rd_ptr;
    logic            empty, pop, push;
    logic [36:0]     frame;
    logic [7:0]      shift;
    logic [CW-1:0]   baud_cnt;
    logic [2:0]      bit_idx, byte_idx;
    logic            baud_done, tx_next;

    assign empty     = (wr_ptr == rd_ptr);
    assign fifo_full = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
    assign pop       = (state == IDLE) && !empty;
    // A pop in the same cycle frees a slot, so a full FIFO can still accept.
    assign push      = wb_valid && (!fifo_full || pop);
    assign busy      = (state != IDLE) || !empty;
    assign baud_done = (baud_cnt == '0);

    function automatic logic [7:0] frame_byte(input logic [36:0] f, input logic [2:0] idx);
        case (idx)
            3'd1:    frame_byte = {3'b000, f[36:32]};
            3'd2:    frame_byte = f[31:24];
            3'd3:    frame_byte = f[23:16];
            3'd4:    frame_byte = f[15:8];
            3'd5:    frame_byte = f[7:0];
            default: frame_byte = 8'hA5;
        endcase
    endfunction

    always_ff @(posedge clk) begin
        if (push) mem[wr_ptr[AW-1:0]] <= {wb_rd, wb_data};
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            drop_count <= 8'd0;
        end else begin
            if (push) wr_ptr <= wr_ptr + 1'b1;
            if (pop)  rd_ptr <= rd_ptr + 1'b1;
            if (wb_valid && !push && drop_count != 8'hFF) drop_count <= drop_count + 8'd1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_next;
    end

    always_comb begin
        state_next = state;
        tx_next    = 1'b1;
        case (state)
            IDLE: begin
                if (!empty) state_next = START;
            end
            START: begin
                tx_next = 1'b0;
                if (baud_done) state_next = DATA;
            end
            DATA: begin
                tx_next = shift[0];
                if (baud_done && bit_idx == 3'd7) state_next = STOP;
            end
            STOP: begin
                if (baud_done) state_next = (byte_idx == 3'd5) ? IDLE : START;
            end
            default: state_next = IDLE;
        endcase
    end

    // The line is registered from the decoded level, so it trails the state by one cycle.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            usb_tx   <= 1'b1;
            frame    <= '0;
            shift    <= 8'd0;
            baud_cnt <= '0;
            bit_idx  <= 3'd0;
            byte_idx <= 3'd0;
        end else begin
            usb_tx <= tx_next;
            case (state)
                IDLE: begin
                    if (pop) begin
                        frame    <= mem[rd_ptr[AW-1:0]];
                        byte_idx <= 3'd0;
                        shift    <= 8'hA5;
                        baud_cnt <= BAUD_RELOAD;
                    end
                end
                START: begin
                    if (baud_done) begin
                        baud_cnt <= BAUD_RELOAD;
                        bit_idx  <= 3'd0;
                    end else begin
                        baud_cnt <= baud_cnt - 1'b1;
                    end
                end
                DATA: begin
                    if (baud_done) begin
                        baud_cnt <= BAUD_RELOAD;
                        shift    <= {1'b0, shift[7:1]};
                        bit_idx  <= bit_idx + 3'd1;
                    end else begin
                        baud_cnt <= baud_cnt - 1'b1;
                    end
                end
                STOP: begin
                    if (baud_done) begin
                        baud_cnt <= BAUD_RELOAD;
                        if (byte_idx != 3'd5) begin
                            byte_idx <= byte_idx + 3'd1;
                            shift    <= frame_byte(frame, byte_idx + 3'd1);
                        end
                    end else begin
                        baud_cnt <= baud_cnt - 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_wb_uart_tracer.sv
// Self-checking bench for wb_uart_tracer: a UART line monitor decodes frames into a
// receive queue, which is matched against expected frames queued as events are driven.
module tb_wb_uart_tracer;

    localparam int CPB   = 4;
    localparam int DEPTH = 8;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        wb_valid;
    logic [4:0]  wb_rd;
    logic [31:0] wb_data;
    logic        usb_tx, busy, fifo_full;
    logic [7:0]  drop_count;

    wb_uart_tracer #(.CLKS_PER_BIT(CPB), .FIFO_DEPTH(DEPTH)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .wb_valid   (wb_valid),
        .wb_rd      (wb_rd),
        .wb_data    (wb_data),
        .usb_tx     (usb_tx),
        .busy       (busy),
        .fifo_full  (fifo_full),
        .drop_count (drop_count)
    );

    always #5 clk = ~clk;

    int cycle = 0;
    always @(posedge clk) cycle <= cycle + 1;

    typedef struct {
        logic [4:0]  rd;
        logic [31:0] data;
        logic [47:0] bytes;
    } vec_t;

    typedef struct {
        logic [47:0] bytes;
        int          bit_errs;
        int          fall;
        int          last;
    } rx_t;

    vec_t        vecs[5];
    rx_t         rx_q[$];
    logic [47:0] exp_q[$];
    int          checks = 0;
    int          errors = 0;

    function automatic logic [47:0] exp_frame(input logic [4:0] rd, input logic [31:0] data);
        return {8'hA5, 3'b000, rd, data};
    endfunction

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Line monitor: samples on the falling clock edge, checks each bit holds for CPB cycles.
    int          mon_byte = 0;
    logic        mon_active = 1'b0;
    int          m_bit, m_cyc, m_errs, m_fall;
    logic        m_val;
    logic [7:0]  m_cur;
    logic [47:0] m_got;
    initial begin
        rx_t r;
        forever begin
            @(negedge clk);
            if (!rst_n) begin
                mon_active = 1'b0;
                mon_byte   = 0;
            end else if (!mon_active && usb_tx == 1'b0) begin
                mon_active = 1'b1;
                mon_byte   = 0;
                m_bit      = 0;
                m_cyc      = 0;
                m_errs     = 0;
                m_fall     = cycle;
                m_got      = '0;
            end
            if (rst_n && mon_active) begin
                if (m_cyc == 0) m_val = usb_tx;
                else if (usb_tx !== m_val) m_errs++;
                m_cyc++;
                if (m_cyc == CPB) begin
                    m_cyc = 0;
                    if (m_bit == 0) begin
                        if (m_val !== 1'b0) m_errs++;
                        m_bit++;
                    end else if (m_bit <= 8) begin
                        m_cur[m_bit-1] = m_val;
                        m_bit++;
                    end else begin
                        if (m_val !== 1'b1) m_errs++;
                        m_got = {m_got[39:0], m_cur};
                        mon_byte++;
                        m_bit = 0;
                        if (mon_byte == 6) begin
                            r.bytes    = m_got;
                            r.bit_errs = m_errs;
                            r.fall     = m_fall;
                            r.last     = cycle;
                            rx_q.push_back(r);
                            mon_active = 1'b0;
                            mon_byte   = 0;
                        end
                    end
                end
            end
        end
    end

    task automatic wait_rx(input int n, input int bound, input string name);
        int k = 0;
        while (rx_q.size() < n && k < bound) begin
            @(negedge clk);
            k++;
        end
        chk({name, "_arrived"}, 64'(rx_q.size() >= n), 64'd1);
    endtask

    task automatic compare_frames(input int n, input string name, output rx_t first, output rx_t last);
        rx_t         r;
        logic [47:0] e;
        first = '{default: 0};
        last  = '{default: 0};
        for (int k = 0; k < n; k++) begin
            if (rx_q.size() > 0 && exp_q.size() > 0) begin
                r = rx_q.pop_front();
                e = exp_q.pop_front();
                chk({name, "_bytes"}, 64'(r.bytes), 64'(e));
                chk({name, "_bit_timing"}, 64'(r.bit_errs), 64'd0);
                if (k == 0) first = r;
                last = r;
            end
        end
    endtask

    initial begin
        rx_t r1, r2;
        int  e, e0, k;
        logic [4:0]  rd;
        logic [31:0] data;

        vecs[0] = '{5'd10, 32'h0000_007D, 48'hA5_0A_00_00_00_7D};
        vecs[1] = '{5'd2,  32'h0000_0005, 48'hA5_02_00_00_00_05};
        vecs[2] = '{5'd4,  32'hFFFF_FFFD, 48'hA5_04_FF_FF_FF_FD};
        vecs[3] = '{5'd0,  32'hDEAD_BEEF, 48'hA5_00_DE_AD_BE_EF};
        vecs[4] = '{5'd31, 32'h8000_0001, 48'hA5_1F_80_00_00_01};

        rst_n = 1'b0; wb_valid = 1'b0; wb_rd = '0; wb_data = '0;

        // Reset held with activity on the write-back port.
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            wb_valid = ~wb_valid;
            wb_rd    = 5'(i);
            wb_data  = 32'(i * 3);
        end
        chk("rst_usb_tx", 64'(usb_tx), 64'd1);
        chk("rst_busy", 64'(busy), 64'd0);
        chk("rst_drop", 64'(drop_count), 64'd0);
        chk("rst_full", 64'(fifo_full), 64'd0);
        wb_valid = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        repeat (20) @(negedge clk);
        chk("post_rst_line", 64'(usb_tx), 64'd1);
        chk("post_rst_busy", 64'(busy), 64'd0);
        chk("post_rst_no_frames", 64'(rx_q.size()), 64'd0);

        // Single events from idle, one vector at a time.
        foreach (vecs[i]) begin
            @(negedge clk);
            e = cycle + 1;
            wb_valid = 1'b1; wb_rd = vecs[i].rd; wb_data = vecs[i].data;
            exp_q.push_back(vecs[i].bytes);
            @(negedge clk);
            wb_valid = 1'b0;
            wait_rx(1, 400, "single");
            compare_frames(1, "single", r1, r2);
            chk("single_latency", 64'(r1.fall - e), 64'd2);
            chk("single_length", 64'(r1.last - r1.fall + 1), 64'(60 * CPB));
            repeat (3) @(negedge clk);
            chk("single_idle_busy", 64'(busy), 64'd0);
        end

        // Two events on consecutive cycles.
        @(negedge clk);
        wb_valid = 1'b1; wb_rd = 5'd2; wb_data = 32'd5;
        exp_q.push_back(exp_frame(5'd2, 32'd5));
        @(negedge clk);
        wb_rd = 5'd4; wb_data = 32'hFFFF_FFFD;
        exp_q.push_back(exp_frame(5'd4, 32'hFFFF_FFFD));
        @(negedge clk);
        wb_valid = 1'b0;
        wait_rx(2, 700, "pair");
        compare_frames(2, "pair", r1, r2);
        chk("pair_gap", 64'(r2.fall - r1.last - 1), 64'd1);
        repeat (5) @(negedge clk);

        // Overflow: 12 back-to-back events, 9 survive.
        @(negedge clk);
        e0 = cycle + 1;
        for (int i = 0; i < 12; i++) begin
            wb_valid = 1'b1; wb_rd = 5'(i + 1); wb_data = 32'h1111_0000 + 32'(i);
            if (i < 9) exp_q.push_back(exp_frame(5'(i + 1), 32'h1111_0000 + 32'(i)));
            @(negedge clk);
        end
        wb_valid = 1'b0;
        chk("ovf_full", 64'(fifo_full), 64'd1);
        chk("ovf_drop", 64'(drop_count), 64'd3);
        chk("ovf_busy", 64'(busy), 64'd1);
        k = 0;
        while (fifo_full && k < 400) begin
            @(negedge clk);
            k++;
        end
        chk("ovf_full_release_cycle", 64'(cycle - e0), 64'd242);
        wait_rx(9, 9 * 245 + 50, "ovf");
        compare_frames(9, "ovf", r1, r2);
        repeat (5) @(negedge clk);
        chk("ovf_extra_frames", 64'(rx_q.size()), 64'd0);
        chk("ovf_idle_busy", 64'(busy), 64'd0);

        // Saturation, including a push that coincides with a pop while full.
        for (int i = 0; i < 310; i++) begin
            @(negedge clk);
            if (i == 0) e0 = cycle + 1;
            if (i == 242) begin
                chk("sat_drop_before_pop", 64'(drop_count), 64'd236);
                chk("sat_full_before_pop", 64'(fifo_full), 64'd1);
            end
            if (i == 243) begin
                chk("sat_drop_at_pop", 64'(drop_count), 64'd236);
                chk("sat_full_at_pop", 64'(fifo_full), 64'd1);
            end
            wb_valid = 1'b1; wb_rd = 5'(i); wb_data = 32'(i & 8'hFF);
            if (i == 0) exp_q.push_back(exp_frame(5'd0, 32'd0));
        end
        @(negedge clk);
        wb_valid = 1'b0;
        chk("sat_drop", 64'(drop_count), 64'd255);
        for (int i = 0; i < 5; i++) begin
            wb_valid = 1'b1; wb_rd = 5'd9; wb_data = 32'd9;
            @(negedge clk);
        end
        wb_valid = 1'b0;
        chk("sat_hold", 64'(drop_count), 64'd255);

        // Reset during byte 3 of the second frame while its line is low.
        k = 0;
        while (!(rx_q.size() >= 1 && mon_active && mon_byte == 3 && usb_tx == 1'b0) && k < 600) begin
            @(negedge clk);
            k++;
        end
        chk("midrst_reached_byte3", 64'(k < 600), 64'd1);
        #2 rst_n = 1'b0;
        #1;
        chk("midrst_line_high", 64'(usb_tx), 64'd1);
        chk("midrst_busy", 64'(busy), 64'd0);
        chk("midrst_full", 64'(fifo_full), 64'd0);
        chk("midrst_drop", 64'(drop_count), 64'd0);
        compare_frames(1, "midrst_first", r1, r2);
        exp_q.delete();
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        repeat (3) @(negedge clk);
        chk("midrst_no_partial", 64'(rx_q.size()), 64'd0);
        rd = 5'd7; data = 32'h1234_5678;
        e = cycle + 1;
        wb_valid = 1'b1; wb_rd = rd; wb_data = data;
        exp_q.push_back(exp_frame(rd, data));
        @(negedge clk);
        wb_valid = 1'b0;
        wait_rx(1, 400, "midrst_new");
        compare_frames(1, "midrst_new", r1, r2);
        chk("midrst_new_latency", 64'(r1.fall - e), 64'd2);
        repeat (300) @(negedge clk);
        chk("midrst_no_stale", 64'(rx_q.size()), 64'd0);
        chk("midrst_idle_busy", 64'(busy), 64'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
